data_mem_host_port: RTL

- Responder end of the CPU's external data-memory interface. Holds the shared 24-bit data RAM and serves CPU reads and writes.
- Loads the RAM from a host byte stream (UART RX side) before the CPU runs, and drives chk_receive_done to gate CPU execution.
- Reverse direction: when the CPU halts, streams a result window of RAM back to the host as bytes (UART TX side).

---
 rtl/data_mem_host_port.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/data_mem_host_port.sv
// data_mem_host_port: responder side of the CPU data-memory bus.
// Owns the 24-bit data RAM, fills it from a host byte stream before the
// CPU runs, and streams a result window back to the host after halt.
module data_mem_host_port #(
  parameter int DATA_AW    = 14,
  parameter int DUMP_BASE  = 0,
  parameter int DUMP_WORDS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  input  logic               mem_we_ext,
  input  logic [DATA_AW-1:0] mem_addr_ext,
  input  logic [23:0]        mem_data_in_ext,
  output logic [23:0]        mem_data_out_ext,
  input  logic               cpu_halt,
  output logic               chk_receive_done,
  output logic               tx_valid,
  output logic [7:0]         tx_data,
  input  logic               tx_ready,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_LOAD   = 3'd2,
    S_RUN    = 3'd3,
    S_DUMP   = 3'd4
  } state_t;

  localparam logic [DATA_AW-1:0] LP_BASE    = DATA_AW'(DUMP_BASE);
  localparam logic [15:0]        LP_LAST_K  = 16'(DUMP_WORDS - 1);
  localparam logic               LP_DUMP_EN = (DUMP_WORDS > 0);

  state_t             r_state;
  state_t             w_next_state;

  logic [23:0]        r_mem [2**DATA_AW];

  logic [15:0]        r_n;
  logic [7:0]         r_b_hi;
  logic [7:0]         r_b_mid;
  logic [1:0]         r_bidx;
  logic [DATA_AW-1:0] r_waddr;
  logic [15:0]        r_wcnt;
  logic               r_halt_d;
  logic [DATA_AW-1:0] r_raddr;
  logic [15:0]        r_k;
  logic [1:0]         r_tidx;

  logic               w_ls;
  logic               w_rx_acc;
  logic               w_load_wr;
  logic [15:0]        w_wcnt_inc;
  logic               w_tx_fire;
  logic               w_tx_last;
  logic               w_halt_rise;
  logic [23:0]        w_rd_word;
  logic [23:0]        w_load_word;

  // load_start is honoured everywhere except while dumping; it beats rx_valid
  assign w_ls        = load_start & (r_state != S_DUMP);
  assign w_rx_acc    = rx_valid & ~load_start &
                       ((r_state == S_HDR_HI) || (r_state == S_HDR_LO) || (r_state == S_LOAD));
  assign w_load_wr   = w_rx_acc & (r_state == S_LOAD) & (r_bidx == 2'd2);
  assign w_wcnt_inc  = r_wcnt + 16'd1;
  assign w_tx_fire   = (r_state == S_DUMP) & tx_ready;
  assign w_tx_last   = w_tx_fire & (r_tidx == 2'd2) & (r_k == LP_LAST_K);
  assign w_halt_rise = cpu_halt & ~r_halt_d;
  assign w_rd_word   = r_mem[r_raddr];
  assign w_load_word = {r_b_hi, r_b_mid, rx_data};

  // CPU reads are combinational straight out of the array
  assign mem_data_out_ext = r_mem[mem_addr_ext];

  // RAM write port: host load in LOAD, CPU writes only in RUN; never reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_load_wr) begin
        r_mem[r_waddr] <= w_load_word;
      end else if (mem_we_ext && (r_state == S_RUN) && !load_start) begin
        r_mem[mem_addr_ext] <= mem_data_in_ext;
      end
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_HDR_HI;
    else     r_state <= w_next_state;
  end

  // next-state logic
  always_comb begin
    w_next_state = r_state;
    if (w_ls) begin
      w_next_state = S_HDR_HI;
    end else begin
      case (r_state)
        S_HDR_HI: if (w_rx_acc) w_next_state = S_HDR_LO;
        S_HDR_LO: if (w_rx_acc) w_next_state = ({r_n[15:8], rx_data} == 16'd0) ? S_RUN : S_LOAD;
        S_LOAD:   if (w_load_wr && (w_wcnt_inc == r_n)) w_next_state = S_RUN;
        S_RUN:    if (w_halt_rise && LP_DUMP_EN) w_next_state = S_DUMP;
        S_DUMP:   if (w_tx_last) w_next_state = S_RUN;
        default:  w_next_state = S_HDR_HI;
      endcase
    end
  end

  // outputs decoded from state; tx_data is stable because RAM is frozen in DUMP
  always_comb begin
    busy             = (r_state != S_RUN);
    chk_receive_done = (r_state == S_RUN) || (r_state == S_DUMP);
    tx_valid         = (r_state == S_DUMP);
    tx_data          = 8'd0;
    if (r_state == S_DUMP) begin
      case (r_tidx)
        2'd0:    tx_data = w_rd_word[23:16];
        2'd1:    tx_data = w_rd_word[15:8];
        default: tx_data = w_rd_word[7:0];
      endcase
    end
  end

  // halt edge detector
  always_ff @(posedge clk) begin
    if (rst) r_halt_d <= 1'b0;
    else     r_halt_d <= cpu_halt;
  end

  // partial-byte staging for the word being assembled
  always_ff @(posedge clk) begin
    if (w_rx_acc && (r_state == S_LOAD)) begin
      if (r_bidx == 2'd0) r_b_hi  <= rx_data;
      if (r_bidx == 2'd1) r_b_mid <= rx_data;
    end
  end

  // load and dump counters
  always_ff @(posedge clk) begin
    if (rst || w_ls) begin
      r_n     <= 16'd0;
      r_bidx  <= 2'd0;
      r_waddr <= '0;
      r_wcnt  <= 16'd0;
      r_raddr <= '0;
      r_k     <= 16'd0;
      r_tidx  <= 2'd0;
    end else begin
      case (r_state)
        S_HDR_HI: if (w_rx_acc) r_n[15:8] <= rx_data;
        S_HDR_LO: begin
          if (w_rx_acc) begin
            r_n[7:0] <= rx_data;
            r_waddr  <= '0;
            r_wcnt   <= 16'd0;
            r_bidx   <= 2'd0;
          end
        end
        S_LOAD: begin
          if (w_rx_acc) begin
            if (r_bidx == 2'd2) begin
              r_bidx  <= 2'd0;
              r_waddr <= r_waddr + 1'b1;
              r_wcnt  <= w_wcnt_inc;
            end else begin
              r_bidx <= r_bidx + 2'd1;
            end
          end
        end
        S_RUN: begin
          if (w_halt_rise && LP_DUMP_EN) begin
            r_raddr <= LP_BASE;
            r_k     <= 16'd0;
            r_tidx  <= 2'd0;
          end
        end
        S_DUMP: begin
          if (w_tx_fire) begin
            if (r_tidx == 2'd2) begin
              r_tidx  <= 2'd0;
              r_raddr <= r_raddr + 1'b1;
              r_k     <= r_k + 16'd1;
            end else begin
              r_tidx <= r_tidx + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
